src_control_unit: RTL and testbench

- Control sequencer for the SRC single-bus datapath.
- Steps each instruction through fetch (T0–T2) and class-specific execute steps (T3–T7).
- Drives register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) into the register select/encode logic, plus bus, ALU and memory strobes.
- Handshakes with memory through mem_ready, with a timeout fault.

---
 rtl/src_ctrl_pkg.sv | 48 ++++
 rtl/src_mem_wait_timer.sv | 40 ++++
 rtl/src_control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_src_control_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the SRC control sequencer:
// opcodes, ALU codes, step states and instruction classes.
package src_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_e;

    typedef enum logic [2:0] {
        C_NOP, C_R, C_I, C_LD, C_LDI, C_ST, C_BR, C_HALT
    } iclass_e;

    // Unknown opcodes fall into C_NOP.
    function automatic iclass_e classify(input logic [4:0] op);
        iclass_e c;
        case (op)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_SHR, OP_SHL:    c = C_R;
            OP_ADDI, OP_ANDI, OP_ORI: c = C_I;
            OP_LD:                    c = C_LD;
            OP_LDI:                   c = C_LDI;
            OP_ST:                    c = C_ST;
            OP_BR:                    c = C_BR;
            OP_HALT:                  c = C_HALT;
            default:                  c = C_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/src_mem_wait_timer.sv
// Memory wait timer: counts cycles while en_i, cleared by clr_i.
// Ports: clk, rst_n, clr_i, en_i -> timeout_o (last allowed wait cycle).
module src_mem_wait_timer #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int TW = $clog2(MAX + 2);
    localparam logic [TW-1:0] LIMIT = TW'(MAX > 0 ? MAX - 1 : 0);
    localparam bit ENABLED = (MAX > 0);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the MAX-th consecutive wait cycle.
    assign timeout_o = ENABLED && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/src_control_unit.sv
// SRC single-bus control sequencer: fetch T0-T2, execute T3-T7.
// Ports: clk, reset_n, ir, con_ff, mem_ready -> strobes, alu_op, run, fault.
module src_control_unit
    import src_ctrl_pkg::*;
#(
    parameter int OPW         = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [31:0]    ir,
    input  logic           con_ff,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           PCin,
    output logic           IncPC,
    output logic           MARin,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           Zlowout,
    output logic           Cout,
    output logic           CONin,
    output logic           Read,
    output logic           Write,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           fault
);

    state_e  state_q, state_d;
    logic    fault_q, fault_d;
    iclass_e cls;
    logic    in_wait;
    logic    tmo;
    logic    unused_ir;

    assign cls       = classify(ir[31:27]);
    assign unused_ir = ^ir[26:0];
    assign fault     = fault_q;

    assign in_wait = (state_q == T1)
                  || (state_q == T6 && cls == C_LD)
                  || (state_q == T7 && cls == C_ST);

    src_mem_wait_timer #(
        .MAX(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr_i    (!in_wait || mem_ready),
        .en_i     (in_wait),
        .timeout_o(tmo)
    );

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        unique case (state_q)
            RST: state_d = T0;
            T0:  state_d = T1;
            T1:  state_d = T2;
            T2:  state_d = T3;
            T3: begin
                case (cls)
                    C_NOP:   state_d = T0;
                    C_HALT:  state_d = HALT;
                    default: state_d = T4;
                endcase
            end
            T4:  state_d = T5;
            T5: begin
                case (cls)
                    C_LD, C_ST, C_BR: state_d = T6;
                    default:          state_d = T0;
                endcase
            end
            T6: begin
                case (cls)
                    C_LD, C_ST: state_d = T7;
                    default:    state_d = T0;
                endcase
            end
            T7:   state_d = T0;
            HALT: state_d = HALT;
            default: state_d = RST;
        endcase
        // Wait steps hold until mem_ready, or give up on timeout.
        if (in_wait && !mem_ready) begin
            if (tmo) begin
                state_d = HALT;
                fault_d = 1'b1;
            end else begin
                state_d = state_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        CONin   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        alu_op  = '0;
        run     = (state_q != RST) && (state_q != HALT);
        unique case (state_q)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                case (cls)
                    C_R, C_I: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        Grb   = 1'b1;
                        BAout = 1'b1;
                        Yin   = 1'b1;
                    end
                    C_BR: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        CONin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    C_R: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = OPW'(ir[31:27]);
                    end
                    C_I: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = OPW'(ir[31:27]);
                    end
                    C_LD, C_LDI, C_ST: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = OPW'(ALU_ADD);
                    end
                    C_BR: begin
                        PCout = 1'b1;
                        Yin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (cls)
                    C_R, C_I, C_LDI: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                    end
                    C_LD, C_ST: begin
                        Zlowout = 1'b1;
                        MARin   = 1'b1;
                    end
                    C_BR: begin
                        Cout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = OPW'(ALU_ADD);
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (cls)
                    C_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                    end
                    C_ST: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        MDRin = 1'b1;
                    end
                    C_BR: begin
                        Zlowout = con_ff;
                        PCin    = con_ff;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (cls)
                    C_LD: begin
                        MDRout = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                    end
                    C_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_src_control_unit.sv
// Self-checking bench for src_control_unit: vector table,
// directed corner sequences and random instruction stream.
module tb_src_control_unit;

    localparam int TO = 8;

    localparam logic [19:0] PCOUT  = 20'h80000;
    localparam logic [19:0] PCIN   = 20'h40000;
    localparam logic [19:0] INCPC  = 20'h20000;
    localparam logic [19:0] MARIN  = 20'h10000;
    localparam logic [19:0] MDRIN  = 20'h08000;
    localparam logic [19:0] MDROUT = 20'h04000;
    localparam logic [19:0] IRIN   = 20'h02000;
    localparam logic [19:0] YIN    = 20'h01000;
    localparam logic [19:0] ZIN    = 20'h00800;
    localparam logic [19:0] ZLO    = 20'h00400;
    localparam logic [19:0] COUT   = 20'h00200;
    localparam logic [19:0] CONIN  = 20'h00100;
    localparam logic [19:0] RD     = 20'h00080;
    localparam logic [19:0] WR     = 20'h00040;
    localparam logic [19:0] GRA    = 20'h00020;
    localparam logic [19:0] GRB    = 20'h00010;
    localparam logic [19:0] GRC    = 20'h00008;
    localparam logic [19:0] RIN    = 20'h00004;
    localparam logic [19:0] ROUT   = 20'h00002;
    localparam logic [19:0] BAOUT  = 20'h00001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        mem_ready = 1'b0;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
    logic Zlowout, Cout, CONin, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout, run, fault;
    logic [4:0] alu_op;

    always #5 clk = ~clk;

    src_control_unit #(.OPW(5), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .con_ff(con_ff),
        .mem_ready(mem_ready),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op),
        .run(run), .fault(fault)
    );

    logic [19:0] act;
    logic [26:0] obs;
    assign act = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
                  Yin, Zin, Zlowout, Cout, CONin, Read, Write,
                  Gra, Grb, Grc, Rin, Rout, BAout};
    assign obs = {run, fault, alu_op, act};

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [26:0] got,
                       input logic [26:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    function automatic logic [26:0] ex(input bit r, input bit f,
                                       input logic [4:0] a,
                                       input logic [19:0] s);
        return {r, f, a, s};
    endfunction

    typedef struct packed {
        logic [19:0] s;
        logic [4:0]  alu;
        bit          w;
    } step_t;

    step_t plan[$];

    function automatic step_t mk(input logic [19:0] s,
                                 input logic [4:0] a, input bit w);
        step_t t;
        t.s = s;
        t.alu = a;
        t.w = w;
        return t;
    endfunction

    // 0 nop/other, 1 R, 2 I, 3 ld, 4 ldi, 5 st, 6 br, 7 halt
    function automatic int opclass(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd11: return 1;
            5'd12, 5'd13, 5'd14: return 2;
            5'd0:  return 3;
            5'd1:  return 4;
            5'd2:  return 5;
            5'd19: return 6;
            5'd27: return 7;
            default: return 0;
        endcase
    endfunction

    task automatic halt_check(input string nm, input int n, input bit f);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            ir = $urandom;
            con_ff = 1'($urandom);
            mem_ready = 1'($urandom);
            #1 chk(nm, obs, ex(0, f, 5'd0, 20'd0));
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset_n = 1'b0;
        #1 chk(nm, obs, 27'd0);
        @(negedge clk);
        #1 chk(nm, obs, 27'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk(nm, obs, 27'd0);
    endtask

    // Expects to be entered just before the negedge of a T0 cycle.
    task automatic run_instr(input string nm, input logic [31:0] iv,
                             input bit cf, input int d1, input int d2,
                             output bit halted);
        logic [4:0] op;
        int k;
        op = iv[31:27];
        k = opclass(op);
        halted = 1'b0;
        plan.delete();
        plan.push_back(mk(PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b0));
        plan.push_back(mk(ZLO | PCIN | RD | MDRIN, 5'd0, 1'b1));
        plan.push_back(mk(MDROUT | IRIN, 5'd0, 1'b0));
        case (k)
            1: begin
                plan.push_back(mk(GRB | ROUT | YIN, 5'd0, 1'b0));
                plan.push_back(mk(GRC | ROUT | ZIN, op, 1'b0));
                plan.push_back(mk(ZLO | GRA | RIN, 5'd0, 1'b0));
            end
            2: begin
                plan.push_back(mk(GRB | ROUT | YIN, 5'd0, 1'b0));
                plan.push_back(mk(COUT | ZIN, op, 1'b0));
                plan.push_back(mk(ZLO | GRA | RIN, 5'd0, 1'b0));
            end
            3, 4, 5: begin
                plan.push_back(mk(GRB | BAOUT | YIN, 5'd0, 1'b0));
                plan.push_back(mk(COUT | ZIN, 5'd3, 1'b0));
                if (k == 4) begin
                    plan.push_back(mk(ZLO | GRA | RIN, 5'd0, 1'b0));
                end else begin
                    plan.push_back(mk(ZLO | MARIN, 5'd0, 1'b0));
                end
                if (k == 3) begin
                    plan.push_back(mk(RD | MDRIN, 5'd0, 1'b1));
                    plan.push_back(mk(MDROUT | GRA | RIN, 5'd0, 1'b0));
                end
                if (k == 5) begin
                    plan.push_back(mk(GRA | ROUT | MDRIN, 5'd0, 1'b0));
                    plan.push_back(mk(WR, 5'd0, 1'b1));
                end
            end
            6: begin
                plan.push_back(mk(GRA | ROUT | CONIN, 5'd0, 1'b0));
                plan.push_back(mk(PCOUT | YIN, 5'd0, 1'b0));
                plan.push_back(mk(COUT | ZIN, 5'd3, 1'b0));
                plan.push_back(mk(cf ? (ZLO | PCIN) : 20'd0, 5'd0, 1'b0));
            end
            default: plan.push_back(mk(20'd0, 5'd0, 1'b0));
        endcase
        for (int i = 0; i < plan.size(); i++) begin
            int n;
            int d;
            bit to;
            d = (i == 1) ? d1 : d2;
            to = plan[i].w && (d >= TO);
            n = !plan[i].w ? 1 : (to ? TO : d + 1);
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                // ir is scrambled while the unit must not look at it
                ir = (i < 2) ? $urandom : iv;
                con_ff = (i < 3) ? 1'($urandom) : cf;
                mem_ready = plan[i].w ? (c == d) : 1'($urandom);
                #1 chk(nm, obs, ex(1, 0, plan[i].alu, plan[i].s));
            end
            if (to) begin
                halt_check(nm, 4, 1'b1);
                halted = 1'b1;
                return;
            end
        end
        if (k == 7) begin
            halt_check(nm, 20, 1'b0);
            halted = 1'b1;
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] ir;
        bit          cf;
        int          d1;
        int          d2;
    } vec_t;

    vec_t tbl[$];
    int ops[15] = '{0, 1, 2, 3, 4, 5, 6, 9, 11, 12, 13, 14, 19, 26, 27};

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit h;
        tbl.push_back('{"add",      32'h18918000, 1'b0, 0, 0});
        tbl.push_back('{"sub",      32'h20123456, 1'b1, 1, 0});
        tbl.push_back('{"and",      32'h28abcdef, 1'b0, 2, 0});
        tbl.push_back('{"or",       32'h30000001, 1'b0, 0, 0});
        tbl.push_back('{"shr",      32'h48765432, 1'b1, 0, 0});
        tbl.push_back('{"shl",      32'h58000010, 1'b0, 3, 0});
        tbl.push_back('{"addi",     32'h60800005, 1'b0, 0, 0});
        tbl.push_back('{"andi",     32'h6880000f, 1'b0, 1, 0});
        tbl.push_back('{"ori",      32'h70800100, 1'b1, 0, 0});
        tbl.push_back('{"ldi",      32'h08900004, 1'b0, 0, 0});
        tbl.push_back('{"ld_wait3", 32'h00900004, 1'b0, 1, 3});
        tbl.push_back('{"ld_1cyc",  32'h00900008, 1'b0, 0, 0});
        tbl.push_back('{"st_wait2", 32'h10900004, 1'b0, 0, 2});
        tbl.push_back('{"br_cf1",   32'h98400002, 1'b1, 0, 0});
        tbl.push_back('{"br_cf0",   32'h98400002, 1'b0, 0, 0});
        tbl.push_back('{"nop",      32'hd0000000, 1'b1, 0, 0});
        tbl.push_back('{"undef1f",  32'hf8000000, 1'b0, 0, 0});
        tbl.push_back('{"undef07",  32'h38000000, 1'b0, 0, 0});
        tbl.push_back('{"t1_edge",  32'h18918000, 1'b0, TO - 1, 0});
        tbl.push_back('{"st_edge",  32'h10900004, 1'b0, 0, TO - 1});

        do_reset("reset");

        foreach (tbl[i]) begin
            run_instr(tbl[i].nm, tbl[i].ir, tbl[i].cf,
                      tbl[i].d1, tbl[i].d2, h);
            if (h) do_reset("reset_after_vec");
        end

        run_instr("halt", 32'hd8000000, 1'b0, 0, 0, h);
        do_reset("reset_after_halt");
        run_instr("add_after_halt", 32'h18918000, 1'b0, 0, 0, h);

        run_instr("timeout_t1", 32'h18918000, 1'b0, 50, 0, h);
        do_reset("reset_after_to");
        run_instr("timeout_ld", 32'h00900004, 1'b0, 0, TO, h);
        do_reset("reset_after_to_ld");

        // reset pulsed in the middle of a T1 wait
        @(negedge clk);
        mem_ready = 1'b0;
        #1 chk("mid_t1_t0", obs, ex(1, 0, 5'd0,
                                     PCOUT | MARIN | INCPC | ZIN));
        @(negedge clk);
        #1 chk("mid_t1_t1", obs, ex(1, 0, 5'd0,
                                     ZLO | PCIN | RD | MDRIN));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("mid_t1_abort", obs, 27'd0);
        @(negedge clk);
        #1 chk("mid_t1_hold", obs, 27'd0);
        do_reset("mid_t1_reset");
        run_instr("add_after_abort", 32'h18918000, 1'b0, 0, 0, h);

        for (int n = 0; n < 200; n++) begin
            logic [4:0] op;
            int r;
            int d1;
            int d2;
            r = $urandom_range(0, 19);
            op = (r < 15) ? 5'(ops[r]) : 5'($urandom);
            if (op == 5'd27 && $urandom_range(0, 3) != 0) op = 5'd3;
            d1 = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 3)
                                             : $urandom_range(0, 4);
            d2 = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 3)
                                             : $urandom_range(0, 4);
            run_instr("random", {op, 27'($urandom)}, 1'($urandom),
                      d1, d2, h);
            if (h) do_reset("reset_random");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
